// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the packet-aware 2:1 stream arbiter.
// The state enum and the source encoding used on sel_o live here.
package stream_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOCK_A,
    ARB_LOCK_B
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register carrying {data, last, sel}.
// It loads whenever it is empty or being drained, so drain and reload share a cycle.
module stream_out_reg #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [BIT_WIDTH-1:0] i_data,
  input  logic                 i_last,
  input  logic                 i_sel,
  output logic                 o_load,
  output logic                 o_valid,
  output logic [BIT_WIDTH-1:0] o_data,
  output logic                 o_last,
  output logic                 o_sel,
  input  logic                 i_ready
);

  logic                 r_valid;
  logic [BIT_WIDTH-1:0] r_data;
  logic                 r_last;
  logic                 r_sel;

  assign o_load = !r_valid || i_ready;

  // Payload only changes on a new beat so it stays put while stalled or empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_sel   <= 1'b0;
    end else if (o_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
        r_last <= i_last;
        r_sel  <= i_sel;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_sel   = r_sel;

endmodule

// File: rtl/stream_arb_2to1.sv
// Packet-aware round-robin arbiter merging streams A and B through one output register.
// A granted packet keeps the grant until its last beat; priority flips after every packet.
module stream_arb_2to1
  import stream_arb_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 a_valid_i,
  input  logic [BIT_WIDTH-1:0] a_data_i,
  input  logic                 a_last_i,
  output logic                 a_ready_o,
  input  logic                 b_valid_i,
  input  logic [BIT_WIDTH-1:0] b_data_i,
  input  logic                 b_last_i,
  output logic                 b_ready_o,
  output logic                 y_valid_o,
  output logic [BIT_WIDTH-1:0] y_data_o,
  output logic                 y_last_o,
  input  logic                 y_ready_i,
  output logic                 sel_o
);

  arb_state_e           r_state;
  arb_state_e           w_state_next;
  logic                 r_prio;
  logic                 w_prio_next;
  logic                 w_load;
  logic                 w_a_grant;
  logic                 w_b_grant;
  logic                 w_a_fire;
  logic                 w_b_fire;
  logic                 w_in_valid;
  logic [BIT_WIDTH-1:0] w_in_data;
  logic                 w_in_last;
  logic                 w_in_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
      r_prio  <= SEL_A;
    end else begin
      r_state <= w_state_next;
      r_prio  <= w_prio_next;
    end
  end

  // Grant selection and packet tracking; a locked packet ignores the other source entirely.
  always_comb begin
    w_state_next = r_state;
    w_prio_next  = r_prio;
    w_a_grant    = 1'b0;
    w_b_grant    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (a_valid_i && (!b_valid_i || r_prio == SEL_A)) begin
          w_a_grant = 1'b1;
        end else if (b_valid_i) begin
          w_b_grant = 1'b1;
        end
      end
      ARB_LOCK_A: w_a_grant = 1'b1;
      ARB_LOCK_B: w_b_grant = 1'b1;
      default: w_state_next = ARB_IDLE;
    endcase
    if (w_a_fire) begin
      if (a_last_i) begin
        w_state_next = ARB_IDLE;
        w_prio_next  = SEL_B;
      end else begin
        w_state_next = ARB_LOCK_A;
      end
    end else if (w_b_fire) begin
      if (b_last_i) begin
        w_state_next = ARB_IDLE;
        w_prio_next  = SEL_A;
      end else begin
        w_state_next = ARB_LOCK_B;
      end
    end
  end

  // Readies are forced low while reset is held so nothing is accepted during reset.
  assign a_ready_o  = rst_ni && w_load && w_a_grant;
  assign b_ready_o  = rst_ni && w_load && w_b_grant;
  assign w_a_fire   = a_valid_i && a_ready_o;
  assign w_b_fire   = b_valid_i && b_ready_o;
  assign w_in_valid = w_a_fire || w_b_fire;
  assign w_in_data  = w_b_fire ? b_data_i : a_data_i;
  assign w_in_last  = w_b_fire ? b_last_i : a_last_i;
  assign w_in_sel   = w_b_fire ? SEL_B : SEL_A;

  stream_out_reg #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_out_reg (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_valid (w_in_valid),
    .i_data  (w_in_data),
    .i_last  (w_in_last),
    .i_sel   (w_in_sel),
    .o_load  (w_load),
    .o_valid (y_valid_o),
    .o_data  (y_data_o),
    .o_last  (y_last_o),
    .o_sel   (sel_o),
    .i_ready (y_ready_i)
  );

endmodule

// File: tb/tb_stream_arb_2to1.sv
// Self-checking bench for stream_arb_2to1: directed vector table, reset corner cases,
// and a randomized run against a packet-level round-robin reference model.
module tb_stream_arb_2to1;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       a_valid_i, a_last_i, a_ready_o;
  logic [7:0] a_data_i;
  logic       b_valid_i, b_last_i, b_ready_o;
  logic [7:0] b_data_i;
  logic       y_valid_o, y_last_o, y_ready_i, sel_o;
  logic [7:0] y_data_o;

  int checks   = 0;
  int failures = 0;

  stream_arb_2to1 #(.BIT_WIDTH(8)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .a_valid_i (a_valid_i),
    .a_data_i  (a_data_i),
    .a_last_i  (a_last_i),
    .a_ready_o (a_ready_o),
    .b_valid_i (b_valid_i),
    .b_data_i  (b_data_i),
    .b_last_i  (b_last_i),
    .b_ready_o (b_ready_o),
    .y_valid_o (y_valid_o),
    .y_data_o  (y_data_o),
    .y_last_o  (y_last_o),
    .y_ready_i (y_ready_i),
    .sel_o     (sel_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       al;
    logic       bv;
    logic [7:0] bd;
    logic       bl;
    logic       yr;
    logic       expAr;
    logic       expBr;
    logic       expYv;
    logic [7:0] expYd;
    logic       expYl;
    logic       expSel;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mkVec(logic av, logic [7:0] ad, logic al,
                                 logic bv, logic [7:0] bd, logic bl, logic yr,
                                 logic ear, logic ebr,
                                 logic eyv, logic [7:0] eyd, logic eyl, logic esel);
    vec_t v;
    v.av = av; v.ad = ad; v.al = al;
    v.bv = bv; v.bd = bd; v.bl = bl; v.yr = yr;
    v.expAr = ear; v.expBr = ebr;
    v.expYv = eyv; v.expYd = eyd; v.expYl = eyl; v.expSel = esel;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_valid_i = v.av; a_data_i = v.ad; a_last_i = v.al;
    b_valid_i = v.bv; b_data_i = v.bd; b_last_i = v.bl;
    y_ready_i = v.yr;
  endtask

  // Reference model state for the random phase
  logic       mFull;
  logic [7:0] mData;
  logic       mLast, mSel;
  int         owner, prio, g, fire;
  logic       load, yr;
  logic       expR[2];
  logic       sv[2];
  logic [7:0] sd[2];
  logic       sl[2];
  int         remain[2];

  initial begin
    // Tie A/B, then single-beat stream and backpressure, then an A packet locked against B.
    vecs[0]  = mkVec(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    vecs[1]  = mkVec(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
    vecs[2]  = mkVec(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    vecs[3]  = mkVec(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
    vecs[4]  = mkVec(1'b1, 8'h5C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5C, 1'b1, 1'b0);
    vecs[5]  = mkVec(1'b1, 8'h33, 1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5C, 1'b1, 1'b0);
    vecs[6]  = vecs[5];
    vecs[7]  = vecs[5];
    vecs[8]  = vecs[5];
    vecs[9]  = mkVec(1'b1, 8'h33, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
    vecs[10] = mkVec(1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
    vecs[11] = mkVec(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[12] = mkVec(1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0);
    vecs[13] = mkVec(1'b1, 8'hA1, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0);
    vecs[14] = mkVec(1'b1, 8'hA2, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0);
    vecs[15] = mkVec(1'b1, 8'h99, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1);
    vecs[16] = mkVec(1'b1, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0);

    rst_ni = 1'b0;
    applyStimulus(vecs[0]);
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    checkOutput("rst_y_valid", 32'(y_valid_o), 32'(0));
    checkOutput("rst_y_data",  32'(y_data_o),  32'(0));
    checkOutput("rst_y_last",  32'(y_last_o),  32'(0));
    checkOutput("rst_sel",     32'(sel_o),     32'(0));
    checkOutput("rst_a_ready", 32'(a_ready_o), 32'(0));
    checkOutput("rst_b_ready", 32'(b_ready_o), 32'(0));

    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_a_ready", i), 32'(a_ready_o), 32'(vecs[i].expAr));
      checkOutput($sformatf("v%0d_b_ready", i), 32'(b_ready_o), 32'(vecs[i].expBr));
      @(negedge clk_i);
      checkOutput($sformatf("v%0d_y_valid", i), 32'(y_valid_o), 32'(vecs[i].expYv));
      if (vecs[i].expYv) begin
        checkOutput($sformatf("v%0d_y_data", i), 32'(y_data_o), 32'(vecs[i].expYd));
        checkOutput($sformatf("v%0d_y_last", i), 32'(y_last_o), 32'(vecs[i].expYl));
        checkOutput($sformatf("v%0d_sel", i),    32'(sel_o),    32'(vecs[i].expSel));
      end
    end

    // B packet interrupted by reset after its second beat; A must win afterwards.
    applyStimulus(mkVec(1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    #1;
    checkOutput("mr_b1_b_ready", 32'(b_ready_o), 32'(1));
    @(negedge clk_i);
    checkOutput("mr_b1_data", 32'(y_data_o), 32'(8'hB1));
    b_data_i = 8'hB2;
    @(negedge clk_i);
    checkOutput("mr_b2_data", 32'(y_data_o), 32'(8'hB2));
    checkOutput("mr_b2_sel",  32'(sel_o),    32'(1));
    rst_ni = 1'b0;
    a_valid_i = 1'b1; a_data_i = 8'hC1; a_last_i = 1'b1;
    b_data_i = 8'hB3;
    #1;
    checkOutput("mr_rst_y_valid", 32'(y_valid_o), 32'(0));
    checkOutput("mr_rst_a_ready", 32'(a_ready_o), 32'(0));
    checkOutput("mr_rst_b_ready", 32'(b_ready_o), 32'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("mr_rel_a_ready", 32'(a_ready_o), 32'(1));
    checkOutput("mr_rel_b_ready", 32'(b_ready_o), 32'(0));
    @(negedge clk_i);
    checkOutput("mr_c1_valid", 32'(y_valid_o), 32'(1));
    checkOutput("mr_c1_data",  32'(y_data_o),  32'(8'hC1));
    checkOutput("mr_c1_sel",   32'(sel_o),     32'(0));

    a_valid_i = 1'b0; b_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    mFull = 1'b0; mData = '0; mLast = 1'b0; mSel = 1'b0;
    owner = -1; prio = 0;
    for (int s = 0; s < 2; s++) begin
      sv[s] = 1'b0; sd[s] = '0; sl[s] = 1'b0; remain[s] = 0;
    end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      checkOutput("rnd_y_valid", 32'(y_valid_o), 32'(mFull));
      if (mFull) begin
        checkOutput("rnd_y_data", 32'(y_data_o), 32'(mData));
        checkOutput("rnd_y_last", 32'(y_last_o), 32'(mLast));
        checkOutput("rnd_sel",    32'(sel_o),    32'(mSel));
      end
      for (int s = 0; s < 2; s++) begin
        if (!sv[s] && $urandom_range(0, 99) < 60) begin
          if (remain[s] == 0) remain[s] = $urandom_range(1, 4);
          sv[s] = 1'b1;
          sd[s] = 8'($urandom);
          sl[s] = (remain[s] == 1);
        end
      end
      yr = ($urandom_range(0, 99) < 70);
      a_valid_i = sv[0]; a_data_i = sd[0]; a_last_i = sl[0];
      b_valid_i = sv[1]; b_data_i = sd[1]; b_last_i = sl[1];
      y_ready_i = yr;
      #1;
      load = !mFull || yr;
      if (owner >= 0)          g = owner;
      else if (sv[0] && sv[1]) g = prio;
      else if (sv[0])          g = 0;
      else if (sv[1])          g = 1;
      else                     g = -1;
      expR[0] = load && (g == 0);
      expR[1] = load && (g == 1);
      checkOutput("rnd_a_ready", 32'(a_ready_o), 32'(expR[0]));
      checkOutput("rnd_b_ready", 32'(b_ready_o), 32'(expR[1]));
      fire = -1;
      for (int s = 0; s < 2; s++) if (sv[s] && expR[s]) fire = s;
      if (load) mFull = (fire >= 0);
      if (fire >= 0) begin
        mData = sd[fire];
        mLast = sl[fire];
        mSel  = (fire == 1);
        if (sl[fire]) begin
          owner = -1;
          prio  = 1 - fire;
        end else begin
          owner = fire;
        end
        remain[fire] = remain[fire] - 1;
        sv[fire] = 1'b0;
      end
      @(negedge clk_i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
